// File: rtl/cordic_hyperbolic_iter_if.sv
// Operand/result handshake bundle for the hyperbolic CORDIC engine.
// The engine connects through the slave modport; the feeding block uses master.
interface cordic_hyperbolic_iter_if #(
   parameter int FIXED_WIDTH = 16
);
   logic                          in_valid;
   logic                          in_ready;
   logic                          mode;
   logic signed [FIXED_WIDTH-1:0] x_in;
   logic signed [FIXED_WIDTH-1:0] y_in;
   logic signed [FIXED_WIDTH-1:0] z_in;
   logic                          out_valid;
   logic                          out_ready;
   logic signed [FIXED_WIDTH-1:0] x_out;
   logic signed [FIXED_WIDTH-1:0] y_out;
   logic signed [FIXED_WIDTH-1:0] z_out;
   logic                          busy;

   modport master (
      output in_valid, mode, x_in, y_in, z_in, out_ready,
      input  in_ready, out_valid, x_out, y_out, z_out, busy
   );

   modport slave (
      input  in_valid, mode, x_in, y_in, z_in, out_ready,
      output in_ready, out_valid, x_out, y_out, z_out, busy
   );
endinterface

// File: rtl/cordic_hyperbolic_iter.sv
// Iterative hyperbolic CORDIC: one micro-rotation per clock, repeats at i = 4, 13, 40.
// Rotation mode drives z to 0 (cosh/sinh); vectoring mode drives y to 0 (atanh, K*sqrt).
module cordic_hyperbolic_iter #(
   parameter int FIXED_WIDTH = 16,
   parameter int FRAC_BITS   = 14,
   parameter int ITERATIONS  = 12
) (
   input logic                     clk,
   input logic                     rst,
   cordic_hyperbolic_iter_if.slave bus
);

   localparam int          W        = FIXED_WIDTH;
   localparam logic [5:0]  LAST_IDX = 6'(ITERATIONS);
   localparam logic [31:0] RND      = 32'd1 << (29 - FRAC_BITS);
   localparam int          SH       = 30 - FRAC_BITS;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state_q, state_d;
   logic signed [W-1:0] x_q, y_q, z_q;
   logic signed [W-1:0] x_n, y_n, z_n;
   logic signed [W-1:0] x_sh, y_sh, t_i;
   logic signed [W-1:0] xo_q, yo_q, zo_q;
   logic [5:0]          idx_q;
   logic                rep_q, mode_q;
   logic                d_pos, need_rep, last;
   logic                in_ready, out_valid, busy;

   // round(atanh(2^-i) * 2^30); from i = 10 on this is exactly 2^(30-i)
   function automatic logic [31:0] atanh_master(input logic [5:0] i);
      case (i)
         6'd1:    return 32'd589812981;
         6'd2:    return 32'd274247419;
         6'd3:    return 32'd134923406;
         6'd4:    return 32'd67196451;
         6'd5:    return 32'd33565361;
         6'd6:    return 32'd16778582;
         6'd7:    return 32'd8388779;
         6'd8:    return 32'd4194325;
         6'd9:    return 32'd2097155;
         default: return (i <= 6'd30) ? (32'd1 << (6'd30 - i)) : 32'd1;
      endcase
   endfunction

   always_comb begin
      x_sh     = x_q >>> idx_q;
      y_sh     = y_q >>> idx_q;
      t_i      = W'((atanh_master(idx_q) + RND) >> SH);
      d_pos    = mode_q ? y_q[W-1] : ~z_q[W-1];
      x_n      = x_q - y_sh;
      y_n      = y_q - x_sh;
      z_n      = z_q + t_i;
      if (d_pos) begin
         x_n = x_q + y_sh;
         y_n = y_q + x_sh;
         z_n = z_q - t_i;
      end
      need_rep = ~rep_q && (idx_q == 6'd4 || idx_q == 6'd13 || idx_q == 6'd40);
      last     = (idx_q == LAST_IDX) && ~need_rep;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = ~rst;
            if (bus.in_valid) state_d = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         idx_q   <= '0;
         rep_q   <= 1'b0;
         mode_q  <= 1'b0;
         xo_q    <= '0;
         yo_q    <= '0;
         zo_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && bus.in_valid) begin
            x_q    <= bus.x_in;
            y_q    <= bus.y_in;
            z_q    <= bus.z_in;
            mode_q <= bus.mode;
            idx_q  <= 6'd1;
            rep_q  <= 1'b0;
         end else if (state_q == RUN) begin
            x_q <= x_n;
            y_q <= y_n;
            z_q <= z_n;
            if (need_rep) begin
               rep_q <= 1'b1;
            end else begin
               rep_q <= 1'b0;
               idx_q <= idx_q + 6'd1;
            end
            // result registers only move on the final micro-iteration
            if (last) begin
               xo_q <= x_n;
               yo_q <= y_n;
               zo_q <= z_n;
            end
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.busy      = busy;
   assign bus.x_out     = xo_q;
   assign bus.y_out     = yo_q;
   assign bus.z_out     = zo_q;

endmodule

// File: tb/tb_cordic_hyperbolic_iter.sv
// Scoreboard bench for cordic_hyperbolic_iter: default build plus a 24-bit/20-frac/16-iteration build.
// Expected results come from an integer reference of the algorithm with angles taken from $atanh.
module tb_cordic_hyperbolic_iter;

   localparam int FW0 = 16, FB0 = 14, IT0 = 12;
   localparam int FW1 = 24, FB1 = 20, IT1 = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cordic_hyperbolic_iter_if #(.FIXED_WIDTH(FW0)) if0 ();
   cordic_hyperbolic_iter_if #(.FIXED_WIDTH(FW1)) if1 ();

   cordic_hyperbolic_iter #(.FIXED_WIDTH(FW0), .FRAC_BITS(FB0), .ITERATIONS(IT0)) u0 (
      .clk(clk), .rst(rst), .bus(if0.slave)
   );
   cordic_hyperbolic_iter #(.FIXED_WIDTH(FW1), .FRAC_BITS(FB1), .ITERATIONS(IT1)) u1 (
      .clk(clk), .rst(rst), .bus(if1.slave)
   );

   typedef struct {
      string  name;
      longint ex, ey, ez;
      bit     has_math;
      longint ax, ay, az;
      longint tx, ty, tz;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string tag, input longint got, input longint exp, input longint tol);
      longint d;
      d = got - exp;
      if (d < 0) d = -d;
      n_tests++;
      if (d > tol) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
      end
   endtask

   function automatic longint sx(input longint v, input int w);
      return (v <<< (64 - w)) >>> (64 - w);
   endfunction

   function automatic longint t_ref(input int i, input int fb);
      int     k;
      real    a;
      longint c;
      k = (i > 30) ? 30 : i;
      a = $atanh(1.0 / real'(longint'(1) << k));
      c = longint'($rtoi(a * 1073741824.0 + 0.5));
      return (c + (longint'(1) << (29 - fb))) >>> (30 - fb);
   endfunction

   function automatic int steps(input int iters);
      return iters + ((iters >= 4) ? 1 : 0) + ((iters >= 13) ? 1 : 0) + ((iters >= 40) ? 1 : 0);
   endfunction

   task automatic model(input int fw, input int fb, input int iters, input bit md,
                        input longint x0, input longint y0, input longint z0,
                        output longint xr, output longint yr, output longint zr);
      longint x, y, z, t, nx, ny, nz;
      int     i;
      bit     rep, fin, pos;
      x = sx(x0, fw); y = sx(y0, fw); z = sx(z0, fw);
      i = 1; rep = 0; fin = 0;
      while (!fin) begin
         pos = md ? (y < 0) : (z >= 0);
         t   = sx(t_ref(i, fb), fw);
         nx  = pos ? x + (y >>> i) : x - (y >>> i);
         ny  = pos ? y + (x >>> i) : y - (x >>> i);
         nz  = pos ? z - t : z + t;
         x = sx(nx, fw); y = sx(ny, fw); z = sx(nz, fw);
         if ((i == 4 || i == 13 || i == 40) && !rep) begin
            rep = 1;
         end else begin
            if (i == iters) fin = 1;
            rep = 0;
            i++;
         end
      end
      xr = x; yr = y; zr = z;
   endtask

   function automatic exp_t mk(input string name, input bit has_math,
                               input longint ax, input longint ay, input longint az,
                               input longint tx, input longint ty, input longint tz);
      exp_t e;
      e.name = name; e.has_math = has_math;
      e.ax = ax; e.ay = ay; e.az = az;
      e.tx = tx; e.ty = ty; e.tz = tz;
      e.ex = 0; e.ey = 0; e.ez = 0;
      return e;
   endfunction

   task automatic cmp_out(input exp_t e, input longint xo, input longint yo, input longint zo);
      check({e.name, ".x"}, xo, e.ex, 0);
      check({e.name, ".y"}, yo, e.ey, 0);
      check({e.name, ".z"}, zo, e.ez, 0);
      if (e.has_math) begin
         check({e.name, ".x_math"}, xo, e.ax, e.tx);
         check({e.name, ".y_math"}, yo, e.ay, e.ty);
         check({e.name, ".z_math"}, zo, e.az, e.tz);
      end
   endtask

   // Default build: optional DONE backpressure and stray in_valid pulses during RUN.
   task automatic op0(input exp_t e_in, input bit md, input longint x, input longint y,
                      input longint z, input int hold, input bit poke);
      exp_t e, got;
      int   lat;
      e = e_in;
      @(negedge clk);
      check({e.name, ".in_ready"}, if0.in_ready, 1, 0);
      if0.in_valid = 1'b1;
      if0.mode     = md;
      if0.x_in     = FW0'(x);
      if0.y_in     = FW0'(y);
      if0.z_in     = FW0'(z);
      model(FW0, FB0, IT0, md, x, y, z, e.ex, e.ey, e.ez);
      sb0.push_back(e);
      @(posedge clk);
      @(negedge clk);
      if0.in_valid = 1'b0;
      check({e.name, ".busy"}, if0.busy, 1, 0);
      check({e.name, ".in_ready_run"}, if0.in_ready, 0, 0);
      lat = 0;
      while (!if0.out_valid && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (poke) begin
            if0.in_valid = (lat == 3 || lat == 7);
            if0.mode     = 1'($urandom);
            if0.x_in     = FW0'($urandom);
            if0.y_in     = FW0'($urandom);
            if0.z_in     = FW0'($urandom);
         end
      end
      if0.in_valid = 1'b0;
      check({e.name, ".latency"}, lat, steps(IT0), 0);
      got = sb0.pop_front();
      cmp_out(got, if0.x_out, if0.y_out, if0.z_out);
      if0.out_ready = 1'b0;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk);
         @(negedge clk);
         check({got.name, ".hold_valid"}, if0.out_valid, 1, 0);
         check({got.name, ".hold_in_ready"}, if0.in_ready, 0, 0);
         check({got.name, ".hold_x"}, if0.x_out, got.ex, 0);
         check({got.name, ".hold_y"}, if0.y_out, got.ey, 0);
         check({got.name, ".hold_z"}, if0.z_out, got.ez, 0);
      end
      if0.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if0.out_ready = 1'b0;
      check({got.name, ".post_valid"}, if0.out_valid, 0, 0);
      check({got.name, ".post_in_ready"}, if0.in_ready, 1, 0);
      check({got.name, ".idle_x"}, if0.x_out, got.ex, 0);
      if (poke) begin
         @(posedge clk);
         @(negedge clk);
         check({got.name, ".no_stray_start"}, if0.busy, 0, 0);
      end
   endtask

   task automatic op1(input string name, input bit md, input longint x, input longint y,
                      input longint z);
      exp_t e, got;
      int   lat;
      e = mk(name, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      if1.in_valid = 1'b1;
      if1.mode     = md;
      if1.x_in     = FW1'(x);
      if1.y_in     = FW1'(y);
      if1.z_in     = FW1'(z);
      model(FW1, FB1, IT1, md, x, y, z, e.ex, e.ey, e.ez);
      sb1.push_back(e);
      @(posedge clk);
      @(negedge clk);
      if1.in_valid = 1'b0;
      lat = 0;
      while (!if1.out_valid && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check({name, ".latency"}, lat, steps(IT1), 0);
      got = sb1.pop_front();
      cmp_out(got, if1.x_out, if1.y_out, if1.z_out);
      if1.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if1.out_ready = 1'b0;
      check({name, ".post_valid"}, if1.out_valid, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t c1;
      rst = 1'b1;
      if0.in_valid = 1'b0; if0.out_ready = 1'b0; if0.mode = 1'b0;
      if0.x_in = '0; if0.y_in = '0; if0.z_in = '0;
      if1.in_valid = 1'b0; if1.out_ready = 1'b0; if1.mode = 1'b0;
      if1.x_in = '0; if1.y_in = '0; if1.z_in = '0;
      repeat (2) @(negedge clk);
      check("reset.in_ready", if0.in_ready, 0, 0);
      check("reset.out_valid", if0.out_valid, 0, 0);
      check("reset.busy", if0.busy, 0, 0);
      check("reset.x_out", if0.x_out, 0, 0);
      check("reset.z_out", if0.z_out, 0, 0);
      rst = 1'b0;
      #1;
      check("reset.in_ready_after", if0.in_ready, 1, 0);

      c1 = mk("rot_pos", 1, 18475, 8538, 0, 6, 6, 4);
      op0(c1, 1'b0, 19784, 0, 8192, 0, 1'b0);
      op0(mk("rot_neg", 1, 18475, -8538, 0, 6, 6, 4), 1'b0, 19784, 0, -8192, 0, 1'b0);
      // y==0 steering decisions leave the angle a few LSB above atanh(0.5)
      op0(mk("vec", 1, 11751, 0, 9000, 6, 4, 10), 1'b1, 16384, 8192, 0, 0, 1'b0);
      op0(mk("backpressure", 1, 18475, 8538, 0, 6, 6, 4), 1'b0, 19784, 0, 8192, 5, 1'b1);

      // abort in the sixth RUN cycle; aborted result never reaches the scoreboard
      @(negedge clk);
      if0.in_valid = 1'b1; if0.mode = 1'b0;
      if0.x_in = 16'sd19784; if0.y_in = '0; if0.z_in = 16'sd8192;
      @(posedge clk);
      @(negedge clk);
      if0.in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort.in_ready_in_reset", if0.in_ready, 0, 0);
      @(posedge clk);
      @(negedge clk);
      check("abort.out_valid", if0.out_valid, 0, 0);
      check("abort.busy", if0.busy, 0, 0);
      check("abort.x_out", if0.x_out, 0, 0);
      check("abort.y_out", if0.y_out, 0, 0);
      check("abort.z_out", if0.z_out, 0, 0);
      rst = 1'b0;
      #1;
      check("abort.in_ready_after", if0.in_ready, 1, 0);
      op0(mk("after_abort", 1, 18475, 8538, 0, 6, 6, 4), 1'b0, 19784, 0, 8192, 0, 1'b0);

      for (int n = 0; n < 4; n++) begin
         longint rx, ry, rz;
         rx = longint'($urandom_range(20000, 8000));
         if (n < 2) begin
            ry = longint'($urandom_range(8000, 0)) - 4000;
            rz = longint'($urandom_range(36000, 0)) - 18000;
            op0(mk($sformatf("rand_rot%0d", n), 0, 0, 0, 0, 0, 0, 0), 1'b0, rx, ry, rz, n, 1'b0);
         end else begin
            ry = longint'($urandom_range(longint'(rx), 0)) - rx / 2;
            rz = longint'($urandom_range(4000, 0)) - 2000;
            op0(mk($sformatf("rand_vec%0d", n), 0, 0, 0, 0, 0, 0, 0), 1'b1, rx, ry, rz, 0, 1'b0);
         end
      end

      op1("w24_rot", 1'b0, 1266152, 0, 524288);
      op1("w24_rot_neg", 1'b0, 1266152, 0, -524288);
      op1("w24_vec", 1'b1, 1048576, 524288, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
